// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the N-master round-robin arbiter.
//   state_t         : arbiter FSM states (IDLE, OWN)
//   clog2()         : index width helper, never returns less than 1
//   onehot_to_index : binary index of a one-hot vector (up to MAX_N bits)
package rr_arb_pkg;

    localparam int unsigned MAX_N    = 16;
    localparam int unsigned MAX_ID_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Width needed to index v items; at least 1 so N=1 still gets a real bus.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

    // OR-combine the indices of set bits; exact for a one-hot input.
    function automatic logic [MAX_ID_W-1:0] onehot_to_index(input logic [MAX_N-1:0] oh);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   e      : eligible request vector
//   last   : index of the most recent winner; search starts at last+1
//   found  : at least one eligible bit
//   idx    : winning index
//   onehot : winning index as a one-hot vector (zero when !found)
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    e,
    input  logic [ID_W-1:0] last,
    output logic            found,
    output logic [ID_W-1:0] idx,
    output logic [N-1:0]    onehot
);

    localparam int W2 = 2 * N;

    logic [W2-1:0] dbl;
    logic [W2-1:0] masked;
    logic [W2-1:0] lowest;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search above position 'last'; folding the two halves
    // back together gives the winner modulo N.
    always_comb begin
        dbl    = {e, e};
        masked = '0;
        for (int unsigned i = 0; i < W2; i++) begin
            masked[i] = dbl[i] && (i > 32'(last));
        end
        lowest = masked & (~masked + W2'(1));
        onehot = lowest[N-1:0] | lowest[W2-1:N];
        found  = |e;
        idx    = ID_W'(onehot_to_index(MAX_N'(onehot)));
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-master round-robin bus arbiter with enable masking and bounded tenure.
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   cyc       : per-master bus-cycle request
//   req_mask  : per-master enable for new arbitration
//   gnt       : registered one-hot grant
//   gnt_id    : registered binary index of the grant (0 when idle)
//   gnt_valid : registered grant-active flag
//   comcyc    : bus busy, the granted master's cyc while a grant is active
//   preempt   : registered one-cycle pulse when a tenure is cut by MAX_HOLD
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    cyc,
    input  logic [N-1:0]    req_mask,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            comcyc,
    output logic            preempt
);

    localparam int HC_W = clog2((MAX_HOLD > 1) ? MAX_HOLD : 2);
    localparam logic [HC_W-1:0] HOLD_TOP = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t          state, state_nxt;
    logic [HC_W-1:0] hold_cnt, hold_nxt;
    logic [ID_W-1:0] last, last_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [ID_W-1:0] id_nxt;
    logic            valid_nxt;
    logic            pre_nxt;

    logic [N-1:0]    elig;
    logic [N-1:0]    pick_e;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [N-1:0]    pick_oh;
    logic            owner_cyc;
    logic            at_limit;
    logic            load;
    logic            cut;

    assign elig      = cyc & req_mask;
    // While owning, the owner is excluded so handoff/preemption always moves on.
    assign pick_e    = (state == OWN) ? (elig & ~gnt) : elig;
    assign owner_cyc = |(cyc & gnt);
    assign at_limit  = (MAX_HOLD > 0) && (hold_cnt == HOLD_TOP);
    assign comcyc    = gnt_valid & owner_cyc;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .e      (pick_e),
        .last   (last),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last      <= ID_W'(N - 1);
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= id_nxt;
            gnt_valid <= valid_nxt;
            preempt   <= pre_nxt;
            hold_cnt  <= hold_nxt;
            last      <= last_nxt;
        end
    end

    // Release takes precedence over the tenure limit, so a cut only
    // happens while the owner is still holding cyc.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cut       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWN;
                    load      = 1'b1;
                end
            end
            OWN: begin
                if (!owner_cyc) begin
                    if (pick_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (at_limit && pick_found) begin
                    load = 1'b1;
                    cut  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        valid_nxt = gnt_valid;
        pre_nxt   = cut;
        last_nxt  = last;
        hold_nxt  = (hold_cnt == HOLD_TOP) ? hold_cnt : hold_cnt + HC_W'(1);
        if (load) begin
            gnt_nxt   = pick_oh;
            id_nxt    = pick_idx;
            valid_nxt = 1'b1;
            last_nxt  = pick_idx;
            hold_nxt  = '0;
        end else if (state_nxt == IDLE) begin
            gnt_nxt   = '0;
            id_nxt    = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] cyc;
    logic [N-1:0] req_mask;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         gnt_valid;
    logic         comcyc;
    logic         preempt;

    int vectors     = 0;
    int miscompares = 0;

    rr_arbiter_n #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cyc       (cyc),
        .req_mask  (req_mask),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .comcyc    (comcyc),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Owner is an integer (-1 = nobody); tenure counts owned cycles.
    int m_owner  = -1;
    int m_last   = N - 1;
    int m_owned  = 0;
    bit m_pre    = 1'b0;
    int waited[N];

    function automatic int next_winner(input logic [N-1:0] c, input logic [N-1:0] m,
                                       input int from, input int excl);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (from + k) % N;
            if (c[j] && m[j] && j != excl) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int  w;
        bit  granted;
        logic [N-1:0] exp_gnt;
        logic [1:0]   exp_id;
        logic         exp_valid, exp_com;

        granted = 1'b0;
        if (!rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_owned = 0;
            m_pre   = 1'b0;
            for (int i = 0; i < N; i++) waited[i] = 0;
        end else begin
            m_pre = 1'b0;
            w = next_winner(cyc, req_mask, m_last, m_owner);
            if (m_owner < 0) begin
                granted = (w >= 0);
            end else if (!cyc[m_owner]) begin
                granted = (w >= 0);
                if (w < 0) m_owner = -1;
            end else if (MAX_HOLD > 0 && m_owned + 1 >= MAX_HOLD && w >= 0) begin
                granted = 1'b1;
                m_pre   = 1'b1;
            end else begin
                m_owned = m_owned + 1;
            end
            if (granted) begin
                m_owner = w;
                m_last  = w;
                m_owned = 0;
            end
            // A continuously eligible master must not see more than N-1
            // grants go to others before its own turn.
            for (int i = 0; i < N; i++) begin
                if (!(cyc[i] && req_mask[i]) || i == m_owner) begin
                    waited[i] = 0;
                end else if (granted) begin
                    waited[i] = waited[i] + 1;
                    check("no_starve", 32'(waited[i] <= N - 1), 32'd1);
                end
            end
        end

        #1;
        exp_gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        exp_id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        exp_valid = (m_owner >= 0);
        exp_com   = (m_owner >= 0) && cyc[m_owner];
        check("model_outputs", 32'({gnt, gnt_id, gnt_valid, preempt, comcyc}),
              32'({exp_gnt, exp_id, exp_valid, m_pre, exp_com}));
    end

    // ---------------- stimulus with literal expectations ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        cyc      = '0;
        req_mask = 4'b1111;
        tick();
        tick();
        check("reset_outputs", 32'({gnt, gnt_id, gnt_valid, preempt, comcyc}), 32'd0);

        // Round-robin order with one-cycle releases and no dead cycles.
        rst = 1'b1;
        cyc = 4'b1111; tick(); check("rr_first", 32'(gnt), 32'h1);
        cyc = 4'b1110; tick(); check("rr_to_1", 32'(gnt), 32'h2);
        cyc = 4'b1101; tick(); check("rr_to_2", 32'(gnt), 32'h4);
        cyc = 4'b1011; tick(); check("rr_to_3", 32'(gnt), 32'h8);
        cyc = 4'b0111; tick(); check("rr_wrap_0", 32'(gnt), 32'h1);
        check("rr_valid", 32'(gnt_valid), 32'd1);

        // Single requester and release back to idle.
        cyc = 4'b0000; tick(); check("idle_valid", 32'(gnt_valid), 32'd0);
        cyc = 4'b0100; tick();
        check("single_gnt", 32'({gnt, gnt_id, comcyc}), 32'({4'b0100, 2'd2, 1'b1}));
        cyc = 4'b0000; tick();
        check("single_release", 32'({gnt, gnt_valid, comcyc}), 32'd0);

        // Preemption after MAX_HOLD owned cycles.
        cyc = 4'b0010; tick(); check("pre_grant", 32'(gnt), 32'h2);
        cyc = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick(); check("pre_hold", 32'({gnt, preempt}), 32'({4'b0010, 1'b0}));
        end
        tick(); check("pre_cut", 32'({gnt, preempt}), 32'({4'b1000, 1'b1}));
        tick(); check("pre_pulse_end", 32'({gnt, preempt}), 32'({4'b1000, 1'b0}));

        // Lone holder is never preempted.
        cyc = 4'b0000; tick();
        cyc = 4'b0010;
        for (int i = 0; i < 22; i++) begin
            tick(); check("lone_hold", 32'({gnt, preempt}), 32'({4'b0010, 1'b0}));
        end
        cyc = 4'b0000; tick();

        // Masked requester gets nothing; masking the owner does not revoke.
        req_mask = 4'b1101; cyc = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick(); check("masked_none", 32'(gnt_valid), 32'd0);
        end
        req_mask = 4'b1111; tick(); check("unmask_grant", 32'(gnt), 32'h2);
        req_mask = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            tick(); check("mask_keeps_owner", 32'(gnt), 32'h2);
        end
        cyc = 4'b0000; tick(); check("mask_release", 32'(gnt_valid), 32'd0);

        // Reset mid-tenure, then master 0 wins first.
        req_mask = 4'b1111; cyc = 4'b0100; tick(); check("pre_reset_gnt", 32'(gnt), 32'h4);
        rst = 1'b0; tick();
        check("mid_reset", 32'({gnt, gnt_id, gnt_valid, preempt}), 32'd0);
        rst = 1'b1; cyc = 4'b0000; tick();
        cyc = 4'b1111; tick(); check("after_reset_first", 32'(gnt), 32'h1);

        // Randomized traffic against the model.
        cyc = '0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) cyc[i] = ~cyc[i];
                req_mask[i] = ($urandom_range(7) != 0);
            end
            rst = ($urandom_range(249) != 0);
        end
        rst = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
